// File: rtl/rv32_pc_pkg.sv
// rv32_pc_pkg: shared types and constants for the PC unit and trap-vector logic
package rv32_pc_pkg;
    typedef enum logic [1:0] {BOOT, RUN, WAIT_TRAP} pc_state_e;
    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;
    localparam int STEP_WORD = 4;
    localparam int STEP_HALF = 2;
endpackage

// File: rtl/rv32_trap_vec.sv
// rv32_trap_vec: trap entry target from mtvec, cause and interrupt flag
module rv32_trap_vec
    import rv32_pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [4:0]      trap_cause_i,
    input  logic            trap_interrupt_i,
    output logic [XLEN-1:0] trap_pc_o
);
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_offset;
    assign w_base   = {mtvec_i[XLEN-1:2], 2'b00};
    assign w_offset = {{(XLEN-7){1'b0}}, trap_cause_i, 2'b00};
    // only vectored mode with an interrupt gets a per-cause offset
    always_comb begin
        trap_pc_o = (mtvec_i[1:0] == MTVEC_VECTORED && trap_interrupt_i) ? w_base + w_offset : w_base;
    end
endmodule

// File: rtl/rv32_pc_unit.sv
// rv32_pc_unit: fetch PC register with trap/mret/redirect arbitration and alignment check
module rv32_pc_unit
    import rv32_pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    input  logic            compressed_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic            trap_interrupt_i,
    input  logic [4:0]      trap_cause_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic [XLEN-1:0] pc_o,
    output logic            fetch_valid_o,
    output logic            flush_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] misaligned_addr_o
);
    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 32) ? XLEN'(3) : XLEN'(1);

    pc_state_e       r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic            r_flush;
    logic            r_mis;
    logic [XLEN-1:0] r_mis_addr;
    logic [XLEN-1:0] w_trap_pc;
    logic [XLEN-1:0] w_mret_pc;
    logic [XLEN-1:0] w_step;
    logic            w_redir_mis;

    rv32_trap_vec #(.XLEN(XLEN)) u_trap_vec (
        .mtvec_i          (mtvec_i),
        .trap_cause_i     (trap_cause_i),
        .trap_interrupt_i (trap_interrupt_i),
        .trap_pc_o        (w_trap_pc)
    );

    // return address, step size and redirect alignment for the current cycle
    always_comb begin
        w_mret_pc   = mepc_i & ~ALIGN_MASK;
        w_step      = (IALIGN == 16 && compressed_i) ? XLEN'(STEP_HALF) : XLEN'(STEP_WORD);
        w_redir_mis = (redirect_pc_i & ALIGN_MASK) != '0;
    end

    // state machine: trap > mret > redirect > sequential > hold; pulses default low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VECTOR;
            r_valid    <= 1'b0;
            r_flush    <= 1'b0;
            r_mis      <= 1'b0;
            r_mis_addr <= '0;
        end else begin
            r_flush <= 1'b0;
            r_mis   <= 1'b0;
            case (r_state)
                BOOT: begin
                    r_state <= RUN;
                    r_valid <= 1'b1;
                end
                default: begin
                    if (trap_i) begin
                        r_pc    <= w_trap_pc;
                        r_flush <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= RUN;
                    end else if (r_state == RUN && mret_i) begin
                        r_pc    <= w_mret_pc;
                        r_flush <= 1'b1;
                        r_valid <= 1'b1;
                    end else if (r_state == RUN && redirect_i && w_redir_mis) begin
                        r_mis      <= 1'b1;
                        r_mis_addr <= redirect_pc_i;
                        r_valid    <= 1'b0;
                        r_state    <= WAIT_TRAP;
                    end else if (r_state == RUN && redirect_i) begin
                        r_pc    <= redirect_pc_i;
                        r_flush <= 1'b1;
                        r_valid <= 1'b1;
                    end else if (r_state == RUN && r_valid && fetch_ready_i && !stall_i) begin
                        r_pc <= r_pc + w_step;
                    end
                end
            endcase
        end
    end

    assign pc_o              = r_pc;
    assign fetch_valid_o     = r_valid;
    assign flush_o           = r_flush;
    assign misaligned_o      = r_mis;
    assign misaligned_addr_o = r_mis_addr;
endmodule

// File: tb/tb_rv32_pc_unit.sv
// tb_rv32_pc_unit: directed bench checking IALIGN=32 and IALIGN=16 instances against a behavioural model
module tb_rv32_pc_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        fetch_ready_i = 1'b0;
    logic        compressed_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        trap_i = 1'b0;
    logic        trap_interrupt_i = 1'b0;
    logic [4:0]  trap_cause_i = '0;
    logic [31:0] mtvec_i = '0;
    logic        mret_i = 1'b0;
    logic [31:0] mepc_i = '0;

    logic [31:0] pc_a, maddr_a, pc_b, maddr_b;
    logic        val_a, fl_a, mis_a, val_b, fl_b, mis_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv32_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(32)) dut_a (
        .clk(clk), .reset(reset), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
        .compressed_i(compressed_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .trap_i(trap_i), .trap_interrupt_i(trap_interrupt_i), .trap_cause_i(trap_cause_i),
        .mtvec_i(mtvec_i), .mret_i(mret_i), .mepc_i(mepc_i),
        .pc_o(pc_a), .fetch_valid_o(val_a), .flush_o(fl_a), .misaligned_o(mis_a),
        .misaligned_addr_o(maddr_a)
    );

    rv32_pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(16)) dut_b (
        .clk(clk), .reset(reset), .stall_i(stall_i), .fetch_ready_i(fetch_ready_i),
        .compressed_i(compressed_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .trap_i(trap_i), .trap_interrupt_i(trap_interrupt_i), .trap_cause_i(trap_cause_i),
        .mtvec_i(mtvec_i), .mret_i(mret_i), .mepc_i(mepc_i),
        .pc_o(pc_b), .fetch_valid_o(val_b), .flush_o(fl_b), .misaligned_o(mis_b),
        .misaligned_addr_o(maddr_b)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] maddr;
        logic        valid;
        logic        flush;
        logic        mis;
        logic        waiting;
        logic        booted;
    } mdl_t;

    mdl_t m_a, m_b;
    bit   m_ok = 1'b0;

    function automatic mdl_t nxt(mdl_t m, int ia);
        mdl_t n;
        logic [31:0] base, tgt;
        n = m;
        n.flush = 1'b0;
        n.mis = 1'b0;
        base = mtvec_i - (mtvec_i % 4);
        tgt = (mtvec_i % 4 == 1 && trap_interrupt_i) ? base + 32'(trap_cause_i) * 4 : base;
        if (reset) begin
            n = '0;
        end else if (!m.booted) begin
            n.booted = 1'b1;
            n.valid = 1'b1;
        end else if (trap_i) begin
            n.pc = tgt;
            n.flush = 1'b1;
            n.valid = 1'b1;
            n.waiting = 1'b0;
        end else if (m.waiting) begin
            n = n;
        end else if (mret_i) begin
            n.pc = mepc_i - (mepc_i % (ia / 8));
            n.flush = 1'b1;
            n.valid = 1'b1;
        end else if (redirect_i) begin
            if (redirect_pc_i % (ia / 8) != 0) begin
                n.mis = 1'b1;
                n.maddr = redirect_pc_i;
                n.valid = 1'b0;
                n.waiting = 1'b1;
            end else begin
                n.pc = redirect_pc_i;
                n.flush = 1'b1;
                n.valid = 1'b1;
            end
        end else if (m.valid && fetch_ready_i && !stall_i) begin
            n.pc = m.pc + ((ia == 16 && compressed_i) ? 32'd2 : 32'd4);
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // advance both models on the same edge the DUTs sample their inputs
    always @(posedge clk) begin
        m_a <= nxt(m_a, 32);
        m_b <= nxt(m_b, 16);
        if (reset) m_ok <= 1'b1;
    end

    // every cycle after the first reset edge, compare all outputs to the model
    always @(negedge clk) begin
        if (m_ok) begin
            chk("a_pc", pc_a, m_a.pc);
            chk("a_valid", 32'(val_a), 32'(m_a.valid));
            chk("a_flush", 32'(fl_a), 32'(m_a.flush));
            chk("a_mis", 32'(mis_a), 32'(m_a.mis));
            chk("a_maddr", maddr_a, m_a.maddr);
            chk("b_pc", pc_b, m_b.pc);
            chk("b_valid", 32'(val_b), 32'(m_b.valid));
            chk("b_flush", 32'(fl_b), 32'(m_b.flush));
            chk("b_mis", 32'(mis_b), 32'(m_b.mis));
            chk("b_maddr", maddr_b, m_b.maddr);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        fetch_ready_i = 1'b1;
        tick();
        chk("lit_reset_pc", pc_a, 32'h0);
        chk("lit_reset_valid", 32'(val_a), 32'd0);
        reset = 1'b0;
        tick();
        chk("lit_boot_pc", pc_a, 32'h0);
        chk("lit_boot_valid", 32'(val_a), 32'd1);
        tick();
        chk("lit_seq1", pc_a, 32'h4);
        tick();
        chk("lit_seq2", pc_a, 32'h8);
        tick();
        chk("lit_seq3", pc_a, 32'hC);
        stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h100;
        tick();
        chk("lit_redir_stall_pc", pc_a, 32'h100);
        chk("lit_redir_flush", 32'(fl_a), 32'd1);
        redirect_i = 1'b0;
        tick();
        chk("lit_flush_once", 32'(fl_a), 32'd0);
        chk("lit_stall_hold", pc_a, 32'h100);
        stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h102;
        tick();
        chk("lit_mis_pulse", 32'(mis_a), 32'd1);
        chk("lit_mis_addr", maddr_a, 32'h102);
        chk("lit_mis_pc_hold", pc_a, 32'h100);
        chk("lit_mis_valid", 32'(val_a), 32'd0);
        chk("lit_b_aligned_102", pc_b, 32'h102);
        redirect_pc_i = 32'h300; mret_i = 1'b1; mepc_i = 32'h500;
        tick();
        chk("lit_wait_ignore", pc_a, 32'h100);
        chk("lit_mis_once", 32'(mis_a), 32'd0);
        redirect_i = 1'b0; mret_i = 1'b0; trap_i = 1'b1; mtvec_i = 32'h200;
        tick();
        chk("lit_trap_pc", pc_a, 32'h200);
        chk("lit_trap_valid", 32'(val_a), 32'd1);
        mtvec_i = 32'h1001; trap_interrupt_i = 1'b1; trap_cause_i = 5'd7;
        tick();
        chk("lit_vec_int", pc_a, 32'h101C);
        trap_interrupt_i = 1'b0;
        tick();
        chk("lit_vec_exc", pc_a, 32'h1000);
        chk("lit_b2b_flush", 32'(fl_a), 32'd1);
        mtvec_i = 32'h2003; trap_interrupt_i = 1'b1;
        tick();
        chk("lit_mode11", pc_a, 32'h2000);
        mtvec_i = 32'h400; trap_interrupt_i = 1'b0; mret_i = 1'b1; redirect_i = 1'b1;
        redirect_pc_i = 32'h102; mepc_i = 32'h500;
        tick();
        chk("lit_trap_wins", pc_a, 32'h400);
        chk("lit_trap_no_mis", 32'(mis_a), 32'd0);
        trap_i = 1'b0; redirect_i = 1'b0; mepc_i = 32'h347;
        tick();
        chk("lit_mret_a", pc_a, 32'h344);
        chk("lit_mret_b", pc_b, 32'h346);
        mret_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h10;
        tick();
        redirect_i = 1'b0; compressed_i = 1'b1;
        tick();
        chk("lit_b_half", pc_b, 32'h12);
        chk("lit_a_ignore_c", pc_a, 32'h14);
        compressed_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        tick();
        chk("lit_wrap_a", pc_a, 32'h0);
        chk("lit_wrap_b", pc_b, 32'h0);
        fetch_ready_i = 1'b0;
        tick();
        chk("lit_not_ready_hold", pc_a, 32'h0);
        fetch_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h101;
        tick();
        chk("lit_b_mis", 32'(mis_b), 32'd1);
        chk("lit_b_mis_addr", maddr_b, 32'h101);
        redirect_i = 1'b0; trap_i = 1'b1; mtvec_i = 32'h600;
        tick();
        trap_i = 1'b0;
        tick();
        reset = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h800; trap_i = 1'b1;
        tick();
        chk("lit_midreset_pc", pc_a, 32'h0);
        chk("lit_midreset_valid", 32'(val_a), 32'd0);
        chk("lit_midreset_maddr", maddr_b, 32'h0);
        reset = 1'b0; redirect_i = 1'b0; trap_i = 1'b0;
        tick();
        tick();
        chk("lit_after_reset", pc_a, 32'h4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
